// File: rtl/c64_bus_responder.sv
// c64_bus_responder: 6510 bus responder with on-chip port ($00 DDR, $01 DATA),
// C64 LORAM/HIRAM/CHAREN banking, 1-cycle read return and an I/O handshake.
// Optional I/O wait abort is enabled by defining IO_TIMEOUT_EN.
module c64_bus_responder #(
  parameter int unsigned IO_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] cpu_ab,
  input  logic [7:0]  cpu_do,
  input  logic        cpu_we,
  output logic [7:0]  cpu_di,
  output logic        cpu_rdy,
  output logic [15:0] ram_addr,
  output logic        ram_we,
  output logic [7:0]  ram_wdata,
  input  logic [7:0]  ram_rdata,
  output logic [13:0] rom_addr,
  input  logic [7:0]  rom_rdata,
  output logic [11:0] chr_addr,
  input  logic [7:0]  chr_rdata,
  output logic        io_req,
  output logic        io_we,
  output logic [11:0] io_addr,
  output logic [7:0]  io_wdata,
  input  logic [7:0]  io_rdata,
  input  logic        io_ack,
  input  logic [5:0]  port_in,
  output logic [5:0]  port_out,
  output logic [5:0]  port_oe,
  output logic        io_timeout
);

  localparam int unsigned PW = 6;
  localparam int unsigned DW = 8;

  typedef enum logic [1:0] {IDLE, IO_WAIT, IO_DONE} state_t;
  typedef enum logic [2:0] {SRC_RAM, SRC_ROM, SRC_CHR, SRC_PORT, SRC_IO} src_t;

  if (IO_TIMEOUT < 1 || IO_TIMEOUT > 255) begin : g_bad_timeout
    $error("IO_TIMEOUT must be in 1..255");
  end

  state_t        state, state_nx;
  src_t          src_q, src_c;
  logic [PW-1:0] ddr, data;
  logic [PW-1:0] port_val_c;
  logic [DW-1:0] port_rd, io_rd;
  logic          loram, hiram, charen;
  logic          decode_c, io_hit_c, io_start_c, tmo_c;

  // Banking lines: undriven port pins read back as 1
  assign loram  = data[0] | ~ddr[0];
  assign hiram  = data[1] | ~ddr[1];
  assign charen = data[2] | ~ddr[2];

  assign decode_c   = (state != IO_WAIT);
  assign io_start_c = decode_c & io_hit_c;
  assign port_val_c = cpu_ab[0] ? ((data & ddr) | (port_in & ~ddr)) : ddr;

  // Address map decode for the current CPU cycle
  always_comb begin
    src_c    = SRC_RAM;
    io_hit_c = 1'b0;
    if (cpu_ab[15:1] == 15'd0) begin
      src_c = SRC_PORT;
    end else if (cpu_ab[15:13] == 3'b101 && loram && hiram) begin
      src_c = SRC_ROM;
    end else if (cpu_ab[15:13] == 3'b111 && hiram) begin
      src_c = SRC_ROM;
    end else if (cpu_ab[15:12] == 4'hD && (loram || hiram)) begin
      if (charen) begin
        src_c    = SRC_IO;
        io_hit_c = 1'b1;
      end else begin
        src_c = SRC_CHR;
      end
    end
  end

  // Memory-side address/strobe pass-through
  assign ram_addr  = cpu_ab;
  assign ram_wdata = cpu_do;
  assign ram_we    = cpu_we & decode_c & ~io_hit_c;
  assign rom_addr  = {cpu_ab[14], cpu_ab[12:0]};
  assign chr_addr  = cpu_ab[11:0];
  assign port_out  = data & ddr;
  assign port_oe   = ddr;

`ifdef IO_TIMEOUT_EN
  logic [7:0] wait_cnt;

  assign tmo_c = (state == IO_WAIT) && !io_ack && (wait_cnt == 8'(IO_TIMEOUT - 1));

  // Wait-cycle counter and abort pulse
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wait_cnt   <= 8'd0;
      io_timeout <= 1'b0;
    end else begin
      io_timeout <= tmo_c;
      if (io_start_c) begin
        wait_cnt <= 8'd0;
      end else if (state == IO_WAIT) begin
        wait_cnt <= wait_cnt + 8'd1;
      end
    end
  end
`else
  assign tmo_c      = 1'b0;
  assign io_timeout = 1'b0;
`endif

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  // Next-state logic
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE, IO_DONE: state_nx = io_start_c ? IO_WAIT : IDLE;
      IO_WAIT:       if (io_ack || tmo_c) state_nx = IO_DONE;
      default:       state_nx = IDLE;
    endcase
  end

  // Moore outputs: CPU held and I/O requested only while waiting
  always_comb begin
    cpu_rdy = 1'b1;
    io_req  = 1'b0;
    if (state == IO_WAIT) begin
      cpu_rdy = 1'b0;
      io_req  = 1'b1;
    end
  end

  // Port registers, read-source select and I/O cycle capture
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ddr      <= '0;
      data     <= '0;
      src_q    <= SRC_RAM;
      port_rd  <= '0;
      io_rd    <= '0;
      io_we    <= 1'b0;
      io_addr  <= '0;
      io_wdata <= '0;
    end else begin
      if (decode_c) begin
        src_q   <= src_c;
        port_rd <= {2'b00, port_val_c};
        if (cpu_we && cpu_ab == 16'h0000) ddr  <= cpu_do[PW-1:0];
        if (cpu_we && cpu_ab == 16'h0001) data <= cpu_do[PW-1:0];
        if (io_hit_c) begin
          io_we    <= cpu_we;
          io_addr  <= cpu_ab[11:0];
          io_wdata <= cpu_do;
        end
      end else if (io_ack) begin
        io_rd <= io_we ? 8'h00 : io_rdata;
        io_we <= 1'b0;
      end else if (tmo_c) begin
        io_rd <= 8'hFF;
        io_we <= 1'b0;
      end
    end
  end

  // Read data return mux
  always_comb begin
    cpu_di = ram_rdata;
    unique case (src_q)
      SRC_ROM:  cpu_di = rom_rdata;
      SRC_CHR:  cpu_di = chr_rdata;
      SRC_PORT: cpu_di = port_rd;
      SRC_IO:   cpu_di = io_rd;
      default:  cpu_di = ram_rdata;
    endcase
  end

endmodule
